// File: rtl/msg_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : msg_byte_serializer
// Function : Buffers parser messages in a small FIFO and replays each one as
//            a tlast-delimited 8-bit AXI-stream packet with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module msg_byte_serializer #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int DROP_ERRORS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  input  logic [15:0]                msg_length,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic                       msg_error,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [7:0]                 m_tdata,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       fifo_full,
  output logic [15:0]                drop_count,
  output logic [15:0]                err_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int IDX_W  = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;
  localparam int DATA_W = 8 * MAX_MSG_BYTES;
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  logic [15:0]       mem_len  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic              mem_err  [FIFO_DEPTH];

  state_e           state_q,    state_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      err_cnt_q,  err_cnt_d;

  logic              full;
  logic              send;
  logic              len_bad;
  logic              err_drop;
  logic              push;
  logic              xfer;
  logic              pop;
  logic              last;
  logic [15:0]       head_len;
  logic [DATA_W-1:0] head_data;
  logic              head_err;
  logic [7:0]        head_byte;

  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    send      = (state_q == ST_SEND);
    head_len  = mem_len[rd_ptr_q[AW-1:0]];
    head_data = mem_data[rd_ptr_q[AW-1:0]];
    head_err  = mem_err[rd_ptr_q[AW-1:0]];
    head_byte = head_data[{idx_q, 3'b000} +: 8];
    last      = ({{(16-IDX_W){1'b0}}, idx_q} == (head_len - 16'd1));

    xfer = send && m_tready;
    pop  = xfer && last;

    // Length check outranks the error filter, which outranks overflow.
    len_bad  = (msg_length == 16'd0) || (msg_length > MAX_LEN);
    err_drop = msg_error && (DROP_ERRORS != 0);
    push     = msg_valid && !len_bad && !err_drop && !full;

    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (msg_valid && (len_bad || err_drop)) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (msg_valid && full) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    idx_d = idx_q;
    if (xfer) idx_d = pop ? '0 : (idx_q + IDX_W'(1));

    state_d = (wr_ptr_d != rd_ptr_d) ? ST_SEND : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_len[wr_ptr_q[AW-1:0]]  <= msg_length;
      mem_data[wr_ptr_q[AW-1:0]] <= msg_data;
      mem_err[wr_ptr_q[AW-1:0]]  <= msg_error;
    end
  end

  assign m_tvalid   = send;
  assign m_tdata    = send ? head_byte : 8'h00;
  assign m_tlast    = send && last;
  assign m_tuser    = send && head_err;
  assign fifo_full  = full;
  assign drop_count = drop_cnt_q;
  assign err_count  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_byte_serializer
// Function : Directed scoreboard bench for msg_byte_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_byte_serializer;

  localparam int MAXB = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              msg_valid = 1'b0;
  logic [15:0]       msg_length = '0;
  logic [8*MAXB-1:0] msg_data = '0;
  logic              msg_error = 1'b0;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [7:0]        m_tdata;
  logic              m_tlast;
  logic              m_tuser;
  logic              fifo_full;
  logic [15:0]       drop_count;
  logic [15:0]       err_count;

  int n_cmp = 0;
  int n_err = 0;
  int xfers = 0;

  // Expected beats: {tuser, tlast, tdata}
  logic [9:0] sb[$];

  msg_byte_serializer #(
    .MAX_MSG_BYTES(MAXB),
    .FIFO_DEPTH   (4),
    .DROP_ERRORS  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_length(msg_length),
    .msg_data  (msg_data),
    .msg_error (msg_error),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .fifo_full (fifo_full),
    .drop_count(drop_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on each transfer plus AXI hold check.
  logic       hold_prev = 1'b0;
  logic [9:0] prev_beat = '0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("axi_hold", 64'({m_tvalid, m_tuser, m_tlast, m_tdata}), 64'({1'b1, prev_beat}));
      if (m_tvalid && m_tready) begin
        xfers++;
        check("beat_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0)
          check("beat", 64'({m_tuser, m_tlast, m_tdata}), 64'(sb.pop_front()));
      end
      hold_prev = m_tvalid && !m_tready;
      prev_beat = {m_tuser, m_tlast, m_tdata};
    end
  end

  task automatic push_msg(input logic [15:0] len, input logic [8*MAXB-1:0] data,
                          input logic err, input bit expect_out);
    if (expect_out) begin
      for (int i = 0; i < int'(len); i++)
        sb.push_back({err, (i == int'(len) - 1), data[8*i +: 8]});
    end
    msg_valid  = 1'b1;
    msg_length = len;
    msg_data   = data;
    msg_error  = err;
    @(posedge clk);
    #1;
    msg_valid  = 1'b0;
    msg_error  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [8*MAXB-1:0] d;
    int x0;
    int n;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({m_tvalid, m_tdata, m_tlast, m_tuser, fifo_full, drop_count, err_count}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1. Single message, first beat one cycle after msg_valid
    m_tready = 1'b1;
    d = '0;
    d[31:0] = 32'h8d650d63;
    push_msg(16'd4, d, 1'b0, 1'b1);
    #1;
    check("t1_tvalid_latency", 64'(m_tvalid), 64'd1);
    check("t1_first_byte", 64'({m_tlast, m_tdata}), 64'h063);
    wait_drain("t1_drain", 20);
    check("t1_idle_after", 64'(m_tvalid), 64'd0);

    // 2. Backpressure with toggling ready
    d = '0;
    d[63:0] = 64'h0858138460958803;
    x0 = xfers;
    push_msg(16'd8, d, 1'b0, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      m_tready = ~m_tready;
      n++;
    end
    wait_drain("t2_drain", 20);
    check("t2_transfers", 64'(xfers - x0), 64'd8);

    // 4. Error filter: error flag, zero length, oversize length
    m_tready = 1'b1;
    d = '0;
    d[15:0] = 16'hBEEF;
    push_msg(16'd2, d, 1'b1, 1'b0);
    push_msg(16'd0, d, 1'b0, 1'b0);
    push_msg(16'd33, d, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_egress", 64'(m_tvalid), 64'd0);
    check("t4_err_count", 64'(err_count), 64'd3);
    check("t4_drop_count", 64'(drop_count), 64'd0);

    // 3. Overflow: six messages into a depth-4 FIFO with no ready
    m_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      d = '0;
      d[15:0] = 16'(k);
      push_msg(16'd2, d, 1'b0, (k <= 4));
    end
    check("t3_fifo_full", 64'(fifo_full), 64'd1);
    check("t3_drop_count", 64'(drop_count), 64'd2);
    check("t3_err_unchanged", 64'(err_count), 64'd3);
    m_tready = 1'b1;
    wait_drain("t3_drain", 30);
    repeat (3) @(posedge clk);
    #1;
    check("t3_fifo_not_full", 64'(fifo_full), 64'd0);
    check("t3_idle_after", 64'(m_tvalid), 64'd0);

    // 5. Maximum length followed back-to-back by another message
    for (int k = 0; k < MAXB; k++) d[8*k +: 8] = 8'(k);
    push_msg(16'd32, d, 1'b0, 1'b1);
    d = '0;
    d[15:0] = 16'hA5C3;
    push_msg(16'd2, d, 1'b0, 1'b1);
    n = 0;
    while (m_tvalid && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    check("t5_valid_cycles", 64'(n), 64'd33);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6. Reset mid-message
    d = '0;
    d[63:0] = 64'h8877665544332211;
    x0 = xfers;
    push_msg(16'd8, d, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_reset_xfers", 64'(xfers - x0), 64'd3);
    rst = 1'b0;
    sb.delete();
    #1;
    check("t6_tvalid_in_reset", 64'(m_tvalid), 64'd0);
    check("t6_counters_cleared", 64'({drop_count, err_count}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    d = '0;
    d[31:0] = 32'hD4C3B2A1;
    push_msg(16'd4, d, 1'b0, 1'b1);
    #1;
    check("t6_restart_byte0", 64'({m_tvalid, m_tdata}), 64'h1A1);
    wait_drain("t6_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
